// File: rtl/mux_phase_sequencer.sv
// Sequencer around a combinational halving mux. It latches one input word, then
// steps mux_sel through 0 and 1 and emits one registered half-width beat per select.
module mux_phase_sequencer #(
    parameter int NUM_INPUTS  = 16,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_INPUTS-1:0]   in_data,
    output logic [NUM_INPUTS-1:0]   mux_a,
    output logic                    mux_sel,
    input  logic [NUM_INPUTS/2-1:0] mux_z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_INPUTS/2-1:0] out_data,
    output logic                    out_last
);

    localparam int HALF = NUM_INPUTS / 2;
    localparam int CW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            phase, phase_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NUM_INPUTS-1:0] mux_a_nxt;
    logic            mux_sel_nxt;
    logic [HALF-1:0] out_data_nxt;
    logic            out_valid_nxt;
    logic            out_last_nxt;

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= 1'b0;
            cnt       <= '0;
            mux_a     <= '0;
            mux_sel   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            cnt       <= cnt_nxt;
            mux_a     <= mux_a_nxt;
            mux_sel   <= mux_sel_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
        end
    end

    // mux_z is only captured once the select has been stable for the full hold window.
    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        cnt_nxt       = cnt;
        mux_a_nxt     = mux_a;
        mux_sel_nxt   = mux_sel;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        out_last_nxt  = out_last;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    mux_a_nxt   = in_data;
                    mux_sel_nxt = 1'b0;
                    phase_nxt   = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = SETTLE;
                end
            end
            SETTLE: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    out_data_nxt  = mux_z;
                    out_valid_nxt = 1'b1;
                    out_last_nxt  = phase;
                    state_nxt     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    if (!phase) begin
                        mux_sel_nxt = 1'b1;
                        phase_nxt   = 1'b1;
                        cnt_nxt     = '0;
                        state_nxt   = SETTLE;
                    end else begin
                        mux_sel_nxt  = 1'b0;
                        out_last_nxt = 1'b0;
                        state_nxt    = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux_phase_sequencer.sv
// Directed bench for mux_phase_sequencer: a stub mux drives mux_z, accepted words
// push their two expected beats to a scoreboard that is drained at each output handshake.
module tb_mux_phase_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] mux_a;
    logic        mux_sel;
    logic [7:0]  mux_z;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    logic        delay_mode;
    logic [7:0]  z_raw;
    logic [7:0]  z_dly;

    int checks;
    int failures;
    int cycle;
    int beat_count;
    int accept_count;
    logic [8:0] sb[$];
    int accept_cycles[$];

    mux_phase_sequencer #(.NUM_INPUTS(16), .HOLD_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mux_a     (mux_a),
        .mux_sel   (mux_sel),
        .mux_z     (mux_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Stub mux; delay_mode makes mux_z lag one clock behind a select/word change.
    assign z_raw = mux_sel ? mux_a[15:8] : mux_a[7:0];
    always @(posedge clk) z_dly <= z_raw;
    assign mux_z = delay_mode ? z_dly : z_raw;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge, so the negedge sees the handshake about to happen.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sb.push_back({1'b0, in_data[7:0]});
            sb.push_back({1'b1, in_data[15:8]});
            accept_cycles.push_back(cycle);
            accept_count++;
        end
    end

    always @(negedge clk) begin
        logic [8:0] exp;
        if (rst_n && out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("beat_data", 32'(out_data), 32'(exp[7:0]));
                check("beat_last", 32'(out_last), 32'(exp[8]));
            end
            beat_count++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [15:0] data);
        in_valid = 1'b1;
        in_data  = data;
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int b = budget;
        while (beat_count < n && b > 0) begin
            step(1);
            b--;
        end
        check("beat_wait", 32'(beat_count >= n), 32'd1);
    endtask

    task automatic wait_accepts(input int n, input int budget);
        int b = budget;
        while (accept_count < n && b > 0) begin
            step(1);
            b--;
        end
        check("accept_wait", 32'(accept_count >= n), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int b = budget;
        while (!out_valid && b > 0) begin
            step(1);
            b--;
        end
        check("valid_wait", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int base;
        int a0;
        checks       = 0;
        failures     = 0;
        cycle        = 0;
        beat_count   = 0;
        accept_count = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        delay_mode   = 1'b0;

        // Reset values
        step(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_mux_sel", 32'(mux_sel), 32'd0);
        check("rst_mux_a", 32'(mux_a), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step(1);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single word with first-beat latency
        $display("[TB] single word");
        out_ready = 1'b1;
        base = beat_count;
        send_word(16'hA5C3);
        check("acc_mux_a", 32'(mux_a), 32'hA5C3);
        check("acc_mux_sel", 32'(mux_sel), 32'd0);
        check("acc_in_ready", 32'(in_ready), 32'd0);
        check("acc_out_valid", 32'(out_valid), 32'd0);
        step(1);
        check("e1_out_valid", 32'(out_valid), 32'd0);
        step(1);
        check("e2_out_valid", 32'(out_valid), 32'd1);
        check("e2_out_data", 32'(out_data), 32'hC3);
        check("e2_out_last", 32'(out_last), 32'd0);
        wait_beats(base + 2, 20);
        check("single_in_ready", 32'(in_ready), 32'd1);

        // Backpressure on both beats
        $display("[TB] backpressure");
        out_ready = 1'b0;
        base = beat_count;
        send_word(16'h1234);
        wait_valid(10);
        repeat (5) begin
            check("bp1_valid", 32'(out_valid), 32'd1);
            check("bp1_data", 32'(out_data), 32'h34);
            check("bp1_last", 32'(out_last), 32'd0);
            check("bp1_sel", 32'(mux_sel), 32'd0);
            step(1);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("bp_sel_flip", 32'(mux_sel), 32'd1);
        wait_valid(10);
        repeat (5) begin
            check("bp2_valid", 32'(out_valid), 32'd1);
            check("bp2_data", 32'(out_data), 32'h12);
            check("bp2_last", 32'(out_last), 32'd1);
            check("bp2_sel", 32'(mux_sel), 32'd1);
            step(1);
        end
        out_ready = 1'b1;
        wait_beats(base + 2, 20);
        step(2);
        check("bp_beats", 32'(beat_count), 32'(base + 2));
        check("bp_idle_valid", 32'(out_valid), 32'd0);

        // Settling: delayed mux output must still be sampled correctly
        $display("[TB] settling");
        delay_mode = 1'b1;
        base = beat_count;
        send_word(16'hA5C3);
        wait_beats(base + 2, 20);
        step(1);
        delay_mode = 1'b0;

        // Back-to-back words with in_valid held high
        $display("[TB] back-to-back");
        base = beat_count;
        a0 = accept_count;
        in_valid = 1'b1;
        in_data  = 16'h0F0F;
        wait_accepts(a0 + 1, 10);
        in_data  = 16'hF00F;
        wait_accepts(a0 + 2, 20);
        in_valid = 1'b0;
        wait_beats(base + 4, 30);
        if (accept_cycles.size() >= a0 + 2)
            check("b2b_spacing", 32'(accept_cycles[a0 + 1] - accept_cycles[a0]), 32'd7);

        // Reset during SETTLE of the second beat
        $display("[TB] reset mid-op");
        step(1);
        base = beat_count;
        send_word(16'hBEEF);
        wait_beats(base + 1, 20);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sel", 32'(mux_sel), 32'd0);
        check("mid_rst_mux_a", 32'(mux_a), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        step(2);
        rst_n = 1'b1;
        step(4);
        check("mid_rst_no_beat", 32'(beat_count), 32'(base + 1));
        send_word(16'h5A3C);
        wait_beats(base + 3, 20);
        step(1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_phase_sequencer.md
# mux_phase_sequencer

Control stage wrapped around the combinational `mux_submodule` halving stage. It accepts one NUM_INPUTS-wide word per valid/ready handshake and holds it stable on `mux_a`. It then drives `mux_sel` through 0 and 1, holding each select value for HOLD_CYCLES clocks so the mux output settles. After each hold it samples `mux_z` into a registered, valid/ready-handshaked half-width output stream, so one input word yields two output beats.

## Interface
- NUM_INPUTS, 16, width of the input word; even, ≥ 2; HALF = NUM_INPUTS/2.
- HOLD_CYCLES, 2, clocks `mux_sel` is held before `mux_z` is sampled; ≥ 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  high only in IDLE.
- in_data  input  NUM_INPUTS  upstream word.
- mux_a  output  NUM_INPUTS  registered word driven to the mux `a` input.
- mux_sel  output  1  registered select driven to the mux `sel` input.
- mux_z  input  HALF  mux output, sampled internally.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  HALF  registered sample of `mux_z`.
- out_last  output  1  high on the sel=1 beat (second beat of the word).

## Operation
- States: IDLE, SETTLE, OUT; plus a `phase` bit (0/1) and a hold counter `cnt` of width clog2(HOLD_CYCLES), minimum 1 bit.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: mux_a<=in_data, mux_sel<=0, phase<=0, cnt<=0, go to SETTLE.
- SETTLE:
  - cnt increments each clock.
  - On the edge where cnt==HOLD_CYCLES-1: out_data<=mux_z, out_valid<=1, out_last<=phase, go to OUT.
- OUT:
  - out_valid=1; out_data and out_last are held stable until out_valid&out_ready.
  - On that handshake, if phase==0: mux_sel<=1, phase<=1, cnt<=0, out_valid<=0, go to SETTLE.
  - On that handshake, if phase==1: mux_sel<=0, out_valid<=0, out_last<=0, go to IDLE.
- mux_a changes only on an input accept; it keeps the last word through IDLE.
- in_data is ignored outside IDLE.
- Reset, asynchronous and taking effect immediately, including mid-operation:
  - state=IDLE, phase=0, cnt=0.
  - mux_a=0, mux_sel=0, out_data=0, out_valid=0, out_last=0.
  - Any word in flight is discarded and no partial beat is emitted.
  - in_ready reads 1 during and after reset, but no accept occurs while rst_n is low.
- mux_z is never sampled in the cycle that mux_sel changes; it is sampled only at the end of the hold window.

## Timing
- Accept at edge E:
  - mux_a and mux_sel=0 are valid after E.
  - First capture at edge E+HOLD_CYCLES; out_valid is high from that edge.
- First-beat handshake at edge F:
  - mux_sel=1 after F.
  - Second capture at edge F+HOLD_CYCLES, with out_last=1.
- Second-beat handshake at edge G: IDLE after G, so the next accept is possible at G+1 at the earliest.
- Throughput with out_ready held high and in_valid held high: one word every 2·HOLD_CYCLES+3 clocks (7 clocks at HOLD_CYCLES=2).
- Backpressure: while out_valid&!out_ready, every output and mux_sel is frozen; there is no timeout.
- HOLD_CYCLES=1: capture occurs on the first edge after the select value is applied.

## Test plan
All scenarios use a bench stub for the mux: mux_z = mux_sel ? mux_a[15:8] : mux_a[7:0].

- Reset check: hold rst_n low for 3 clocks → all outputs 0; in_ready=1 after release.
- Single word, in_data=16'hA5C3, out_ready=1:
  - Expect beat 1 out_data=8'hC3, out_last=0, at accept+2 clocks.
  - Expect beat 2 out_data=8'hA5, out_last=1.
  - in_ready returns to 1 afterwards.
- Backpressure: 16'h1234 with out_ready low for 5 clocks on each beat → out_data stays 8'h34 and then 8'h12, out_valid stays high, mux_sel is unchanged while stalled, and exactly 2 beats are delivered.
- Settling: stub delays mux_z by HOLD_CYCLES-1 clocks after a mux_sel change → sampled values are still exactly 8'hC3 and 8'hA5 for 16'hA5C3.
- Back-to-back: in_valid held high with words 16'h0F0F, 16'hF00F, out_ready=1 → accepts 7 clocks apart, and the beat sequence is 0F, 0F, 0F, F0.
- Reset mid-op: assert rst_n low during SETTLE of beat 2 → out_valid=0, mux_sel=0 and mux_a=0 immediately, no out_last beat is emitted, and the next word is processed normally.
